// File: rtl/gate_test_pkg.sv
// Shared types and defaults for the exhaustive gate self-test engine.
// Default truth table describes y = (a & b) | c indexed by {a,b,c}.
package gate_test_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam int N_IN_DEF = 3;
  localparam logic [7:0] TRUTH_AND_OR = 8'hEA;

endpackage

// File: rtl/gate_settle_timer.sv
// Loadable down-counter that stops at zero.
// Used to hold each vector for a fixed number of cycles.
module gate_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_exhaustive_checker.sv
// Walks every input vector of a small gate, samples its output and
// tallies mismatches against a truth-table constant.
module gate_exhaustive_checker
  import gate_test_pkg::*;
#(
  parameter int                 N_IN   = N_IN_DEF,
  parameter int                 SETTLE = 2,
  parameter logic [2**N_IN-1:0] TRUTH  = TRUTH_AND_OR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            drv_a,
  output logic            drv_b,
  output logic            drv_c,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_idx
);

  localparam logic [N_IN-1:0] LAST   = '1;
  localparam logic [N_IN-1:0] ONE    = N_IN'(1);
  localparam logic [N_IN:0]   MAXERR = (N_IN+1)'(2**N_IN);
  localparam logic [3:0]      RELOAD = 4'(SETTLE - 1);

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [N_IN-1:0] nxt;
  logic [N_IN:0]   err_inc;
  logic            mism;
  logic            launch;
  logic            adv;
  logic            load;
  logic            zero;

  // An X on dut_y falls to the else branch and counts as a mismatch.
  always_comb begin
    mism = 1'b1;
    if (dut_y == TRUTH[idx]) begin
      mism = 1'b0;
    end
  end

  always_comb begin
    nxt     = idx + ONE;
    err_inc = (err_cnt == MAXERR) ? err_cnt : err_cnt + (N_IN+1)'(1);
    launch  = start && (state == S_IDLE || state == S_DONE);
    adv     = (state == S_SAMPLE) && (idx != LAST);
    load    = launch || adv;
  end

  gate_settle_timer #(
    .W(4)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(RELOAD),
    .zero    (zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      drv_a      <= 1'b0;
      drv_b      <= 1'b0;
      drv_c      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_SETTLE;
            idx        <= '0;
            drv_a      <= 1'b0;
            drv_b      <= 1'b0;
            drv_c      <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
          end
        end
        S_SETTLE: begin
          if (zero) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (mism) begin
            err_cnt <= err_inc;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_idx   <= idx;
            end
          end
          if (idx == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= mism ? 1'b0 : (err_cnt == '0);
          end else begin
            state <= S_SETTLE;
            idx   <= nxt;
            drv_a <= nxt[2];
            drv_b <= nxt[1];
            drv_c <= nxt[0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Bench for the exhaustive gate checker with a behavioural gate model
// and a truth-table reference computed from y = (a & b) | c.
module tb_gate_exhaustive_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       drv_a, drv_b, drv_c;
  logic       dut_y;
  logic       busy, done, pass;
  logic [3:0] err_cnt;
  logic       fail_valid;
  logic [2:0] fail_idx;
  logic [7:0] gate_tbl;

  int checks = 0;
  int errors = 0;
  int cyc;
  bit pass_early;
  bit busy_gap;
  logic [3:0] snap_err;
  logic       snap_fv, snap_done, snap_busy;
  logic [2:0] drv_log[$];

  always #5 clk = ~clk;

  assign dut_y = gate_tbl[{drv_a, drv_b, drv_c}];

  gate_exhaustive_checker dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .drv_a     (drv_a),
    .drv_b     (drv_b),
    .drv_c     (drv_c),
    .dut_y     (dut_y),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_valid(fail_valid),
    .fail_idx  (fail_idx)
  );

  function automatic bit spec_y(input int i);
    bit a, b, c;
    a = i[2];
    b = i[1];
    c = i[0];
    return (a & b) | c;
  endfunction

  function automatic logic [7:0] tbl_of(input int mode);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0: t[i] = spec_y(i);
        1: t[i] = 1'b0;
        2: t[i] = 1'b1;
        default: t[i] = i[2] & i[1];
      endcase
    end
    return t;
  endfunction

  task automatic ref_model(input logic [7:0] t, output int errs,
                           output int first);
    errs  = 0;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      if (t[i] != spec_y(i)) begin
        errs++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic do_run(input bit mid_start);
    drv_log.delete();
    cyc        = -1;
    pass_early = 0;
    busy_gap   = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        start     = 1'b0;
        snap_err  = err_cnt;
        snap_fv   = fail_valid;
        snap_done = done;
        snap_busy = busy;
      end
      if (mid_start) start = (n == 10);
      if (done) begin
        cyc = n;
        break;
      end
      drv_log.push_back({drv_a, drv_b, drv_c});
      if (pass) pass_early = 1;
      if (!busy) busy_gap = 1;
    end
    start = 1'b0;
  endtask

  task automatic check_outcome(input string tag, input logic [7:0] t);
    int e, f;
    ref_model(t, e, f);
    checks++;
    if (cyc !== 25) begin
      errors++;
      $display("FAIL %s done_cycle got %0d want 25", tag, cyc);
    end
    checks++;
    if (err_cnt !== 4'(e)) begin
      errors++;
      $display("FAIL %s err_cnt got %0d want %0d", tag, err_cnt, e);
    end
    checks++;
    if (pass !== (e == 0) || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s pass/done/busy got %b%b%b want %b10", tag,
               pass, done, busy, (e == 0));
    end
    checks++;
    if (fail_valid !== (e != 0)) begin
      errors++;
      $display("FAIL %s fail_valid got %b want %b", tag, fail_valid,
               (e != 0));
    end
    if (e != 0) begin
      checks++;
      if (fail_idx !== 3'(f)) begin
        errors++;
        $display("FAIL %s fail_idx got %0d want %0d", tag, fail_idx, f);
      end
    end
    checks++;
    if (pass_early || busy_gap) begin
      errors++;
      $display("FAIL %s run_flags pass_early %b busy_gap %b want 0 0",
               tag, pass_early, busy_gap);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, done, pass, err_cnt, fail_valid, fail_idx,
         drv_a, drv_b, drv_c} !== '0) begin
      errors++;
      $display("FAIL reset outputs got %b%b%b %0d %b %0d %b%b%b want 0",
               busy, done, pass, err_cnt, fail_valid, fail_idx,
               drv_a, drv_b, drv_c);
    end
  endtask

  task automatic test_correct;
    int bad;
    gate_tbl = tbl_of(0);
    do_run(0);
    check_outcome("correct", gate_tbl);
    bad = 0;
    foreach (drv_log[k]) if (drv_log[k] !== 3'(k / 3)) bad++;
    checks++;
    if (bad != 0 || drv_log.size() != 24) begin
      errors++;
      $display("FAIL drv_seq bad %0d len %0d want 0 24", bad,
               drv_log.size());
    end
  endtask

  task automatic test_faults;
    for (int m = 1; m <= 3; m++) begin
      gate_tbl = tbl_of(m);
      do_run(0);
      check_outcome($sformatf("fault%0d", m), gate_tbl);
    end
  endtask

  task automatic test_reset_mid_run;
    gate_tbl = tbl_of(0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if ({drv_a, drv_b, drv_c} !== 3'b100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pos drv %b%b%b busy %b want 100 1",
               drv_a, drv_b, drv_c, busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, err_cnt, fail_valid, fail_idx,
         drv_a, drv_b, drv_c} !== '0) begin
      errors++;
      $display("FAIL async_rst outputs busy %b drv %b%b%b want 0",
               busy, drv_a, drv_b, drv_c);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle busy got %b want 0", busy);
    end
    do_run(0);
    check_outcome("after_rst", gate_tbl);
  endtask

  task automatic test_back_to_back;
    gate_tbl = tbl_of(0);
    do_run(1);
    check_outcome("mid_start", gate_tbl);
    gate_tbl = tbl_of(1);
    do_run(0);
    checks++;
    if (snap_err !== 4'd0 || snap_fv !== 1'b0 || snap_done !== 1'b0
        || snap_busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear err %0d fv %b done %b busy %b want 0 0 0 1",
               snap_err, snap_fv, snap_done, snap_busy);
    end
    check_outcome("restart", gate_tbl);
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      gate_tbl = 8'($urandom_range(0, 255));
      do_run($urandom_range(0, 1) == 1);
      check_outcome($sformatf("rand%0d_%h", r, gate_tbl), gate_tbl);
    end
  endtask

  initial begin
    gate_tbl = tbl_of(0);
    #12 rst = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_correct();
    test_faults();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
